// File: rtl/leitor_display_7seg.sv
// Captures a multiplexed 7-segment display bus and decodes each full scan frame back to BCD.
// Optional macro LEITOR_SINC_EN adds a two-flop synchronizer ahead of the sample register.
module leitor_display_7seg #(
  parameter int N_DIGITOS = 4,
  parameter int ESTAVEL   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [6:0]             seg_in,
  input  logic [N_DIGITOS-1:0]   sel_in,
  output logic [4*N_DIGITOS-1:0] valor,
  output logic [N_DIGITOS-1:0]   apagado,
  output logic                   valido,
  output logic                   erro,
  output logic [1:0]             estado
);

  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int CW = $clog2(ESTAVEL + 1);
  localparam logic [IW-1:0] ULTIMO = IW'(N_DIGITOS - 1);
  localparam logic [CW-1:0] ALVO = CW'(ESTAVEL);
  localparam logic [N_DIGITOS-1:0] UM = N_DIGITOS'(1);

  typedef enum logic [1:0] {
    ESPERA     = 2'd0,
    ESTABILIZA = 2'd1,
    CAPTURADO  = 2'd2,
    PUBLICA    = 2'd3
  } estado_t;

  estado_t estado_q, prox;

  logic [6:0]           seg_d;
  logic [N_DIGITOS-1:0] sel_d;

`ifdef LEITOR_SINC_EN
  logic [6:0]           seg_m;
  logic [N_DIGITOS-1:0] sel_m;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_m <= '0;
      sel_m <= '0;
      seg_d <= '0;
      sel_d <= '0;
    end else begin
      seg_m <= seg_in;
      sel_m <= sel_in;
      seg_d <= seg_m;
      sel_d <= sel_m;
    end
  end
`else
  assign seg_d = seg_in;
  assign sel_d = sel_in;
`endif

  logic [6:0]           s_seg;
  logic [N_DIGITOS-1:0] s_sel;
  logic [CW-1:0]        cnt;

  // cnt is the run length of the value currently held in s_seg/s_sel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_seg <= '0;
      s_sel <= '0;
      cnt   <= '0;
    end else begin
      s_seg <= seg_d;
      s_sel <= sel_d;
      if ({seg_d, sel_d} != {s_seg, s_sel}) begin
        cnt <= CW'(1);
      end else if (cnt != ALVO) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  logic [3:0] dec_code;
  logic       dec_blank;
  logic       dec_err;

  always_comb begin
    dec_code  = 4'hF;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (s_seg)
      7'h7E: dec_code = 4'd0;
      7'h30: dec_code = 4'd1;
      7'h6D: dec_code = 4'd2;
      7'h79: dec_code = 4'd3;
      7'h33: dec_code = 4'd4;
      7'h5B: dec_code = 4'd5;
      7'h5F: dec_code = 4'd6;
      7'h70: dec_code = 4'd7;
      7'h7F: dec_code = 4'd8;
      7'h7B: dec_code = 4'd9;
      7'h00: begin
        dec_code  = 4'd0;
        dec_blank = 1'b1;
      end
      default: dec_err = 1'b1;
    endcase
  end

  logic [IW-1:0]        idx;
  logic [N_DIGITOS-1:0] sel_atual;
  logic [N_DIGITOS-1:0] sel_prox;
  logic                 multi;

  assign sel_atual = UM << idx;
  assign sel_prox  = sel_atual << 1;
  assign multi     = |(s_sel & (s_sel - UM));

  logic captura;
  logic avanca;
  logic descarta;
  logic publicar;

  always_comb begin
    prox     = estado_q;
    captura  = 1'b0;
    avanca   = 1'b0;
    descarta = 1'b0;
    publicar = 1'b0;
    case (estado_q)
      ESPERA: begin
        if (s_sel == UM) prox = ESTABILIZA;
      end
      ESTABILIZA: begin
        if (multi || (s_sel != sel_atual)) begin
          prox     = ESPERA;
          descarta = 1'b1;
        end else if (cnt == ALVO) begin
          captura = 1'b1;
          prox    = CAPTURADO;
        end
      end
      CAPTURADO: begin
        // the last digit publishes at once; earlier digits wait for the next select
        if (multi) begin
          prox     = ESPERA;
          descarta = 1'b1;
        end else if (idx == ULTIMO) begin
          publicar = 1'b1;
          prox     = PUBLICA;
        end else if ((s_sel == '0) || (s_sel == sel_atual)) begin
          prox = CAPTURADO;
        end else if (s_sel == sel_prox) begin
          avanca = 1'b1;
          prox   = ESTABILIZA;
        end else begin
          prox     = ESPERA;
          descarta = 1'b1;
        end
      end
      PUBLICA: begin
        prox     = ESPERA;
        descarta = 1'b1;
      end
      default: begin
        prox     = ESPERA;
        descarta = 1'b1;
      end
    endcase
  end

  logic [4*N_DIGITOS-1:0] buf_valor;
  logic [N_DIGITOS-1:0]   buf_apagado;
  logic                   buf_erro;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= ESPERA;
      idx         <= '0;
      buf_valor   <= '0;
      buf_apagado <= '0;
      buf_erro    <= 1'b0;
      valor       <= '0;
      apagado     <= '1;
      erro        <= 1'b0;
    end else begin
      estado_q <= prox;
      if (descarta) begin
        idx         <= '0;
        buf_valor   <= '0;
        buf_apagado <= '0;
        buf_erro    <= 1'b0;
      end else begin
        if (avanca) idx <= idx + IW'(1);
        if (captura) begin
          buf_valor[4*idx +: 4] <= dec_code;
          buf_apagado[idx]      <= dec_blank;
          buf_erro              <= buf_erro | dec_err;
        end
      end
      if (publicar) begin
        valor   <= buf_valor;
        apagado <= buf_apagado;
        erro    <= buf_erro;
      end
    end
  end

  assign valido = (estado_q == PUBLICA);
  assign estado = estado_q;

endmodule
